// File: rtl/eth_pkg.sv
// Shared state encoding and Ethernet framing constants for the RMII transmit MAC.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32.
module crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_crc
);

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    assign next_crc = crc_step(crc, data);

endmodule

// File: rtl/rmii_tx_mac.sv
// Ethernet TX framer: preamble/SFD, pull-handshake payload, zero padding, CRC-32 FCS and IFG onto RMII.
module rmii_tx_mac
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 60,
    parameter int MAX_FRAME = 1514,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_sof,
    input  logic       tx_eof,
    output logic       tx_ack,
    output logic [1:0] rmii_txd,
    output logic       rmii_txen,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int CNT_W  = $clog2(MAX_FRAME + 1);
    localparam int SLOT_W = $clog2(IFG_BYTES * 4);

    localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_FRAME);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_FRAME);
    // The single IDLE cycle before a back-to-back preamble completes the gap.
    localparam logic [SLOT_W-1:0] IFG_LAST = SLOT_W'(IFG_BYTES * 4 - 2);

    tx_state_t         state;
    logic [1:0]        phase;
    logic [CNT_W-1:0]  byte_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [5:0]        shift;
    logic [31:0]       crc;
    logic [31:0]       crc_next;
    logic [7:0]        load_byte;

    always_comb begin
        // NOTE: default assignment first so every path drives load_byte and no latch is inferred.
        load_byte = 8'h00;
        case (state)
            PREAMBLE: load_byte = (slot_cnt == SLOT_W'(7)) ? SFD_BYTE : PREAMBLE_BYTE;
            DATA:     load_byte = tx_data;
            FCS:      load_byte = ~crc[7:0];
            default:  load_byte = 8'h00;
        endcase
    end

    // PAD loads 0x00, so the wire byte is also the CRC input in both CRC'd states.
    crc32_byte u_crc (
        .crc      (crc),
        .data     (load_byte),
        .next_crc (crc_next)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 2'd0;
            byte_cnt   <= '0;
            slot_cnt   <= '0;
            shift      <= 6'd0;
            crc        <= CRC_INIT;
            tx_ack     <= 1'b0;
            rmii_txd   <= 2'b00;
            rmii_txen  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            tx_ack     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rmii_txen  <= 1'b0;
            rmii_txd   <= 2'b00;

            if (state inside {PREAMBLE, DATA, PAD, FCS}) begin
                rmii_txen <= 1'b1;
                phase     <= phase + 2'd1;
                if (phase == 2'd0) begin
                    rmii_txd <= load_byte[1:0];
                    shift    <= load_byte[7:2];
                end else begin
                    rmii_txd <= shift[1:0];
                    shift    <= {2'b00, shift[5:2]};
                end
            end

            case (state)
                IDLE: begin
                    if (tx_sof) begin
                        state    <= PREAMBLE;
                        phase    <= 2'd0;
                        slot_cnt <= '0;
                        byte_cnt <= '0;
                        crc      <= CRC_INIT;
                    end
                end
                PREAMBLE: begin
                    if (phase == 2'd3) begin
                        slot_cnt <= slot_cnt + SLOT_W'(1);
                        if (slot_cnt == SLOT_W'(7)) begin
                            state    <= DATA;
                            slot_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (phase == 2'd0) begin
                        tx_ack   <= 1'b1;
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        crc      <= crc_next;
                    end
                    if (phase == 2'd3) begin
                        if (tx_eof) begin
                            state <= (byte_cnt < MIN_CNT) ? PAD : FCS;
                        end else if (byte_cnt == MAX_CNT) begin
                            frame_err <= 1'b1;
                            state     <= FCS;
                        end
                    end
                end
                PAD: begin
                    if (phase == 2'd0) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        crc      <= crc_next;
                    end
                    if (phase == 2'd3 && byte_cnt >= MIN_CNT)
                        state <= FCS;
                end
                FCS: begin
                    // Shifting in ones leaves the register at CRC_INIT after the fourth byte.
                    if (phase == 2'd0)
                        crc <= {8'hFF, crc[31:8]};
                    if (phase == 2'd3) begin
                        slot_cnt <= slot_cnt + SLOT_W'(1);
                        if (slot_cnt == SLOT_W'(3)) begin
                            frame_done <= 1'b1;
                            state      <= IFG;
                            slot_cnt   <= '0;
                        end
                    end
                end
                IFG: begin
                    if (slot_cnt == IFG_LAST) begin
                        state    <= IDLE;
                        slot_cnt <= '0;
                    end else begin
                        slot_cnt <= slot_cnt + SLOT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_tx_mac.sv
// Bench for rmii_tx_mac: scheduler model, RMII receiver monitor and an expected-byte scoreboard.
module tb_rmii_tx_mac;

    logic       clk_50mhz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data;
    logic       tx_sof = 1'b0;
    logic       tx_eof;
    logic       tx_ack;
    logic [1:0] rmii_txd;
    logic       rmii_txen;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    logic [31:0] unit_crc;
    logic [7:0]  unit_data;
    logic [31:0] unit_next;

    int checks = 0;
    int failures = 0;

    logic [7:0] payload [0:1599];
    int frame_len = 0;
    int acked = 0;
    int ack_total = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_run = -1;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int len_q[$];
    int gap_q[$];
    int idle_q[$];

    rmii_tx_mac dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .tx_ack     (tx_ack),
        .rmii_txd   (rmii_txd),
        .rmii_txen  (rmii_txen),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    crc32_byte u_unit (
        .crc      (unit_crc),
        .data     (unit_data),
        .next_crc (unit_next)
    );

    initial forever #10 clk_50mhz = ~clk_50mhz;

    // Bit-serial reference CRC: feedback is register LSB xor the incoming data bit.
    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Scheduler: presents payload[acked]; tx_eof marks that the last byte has been taken.
    initial begin
        tx_data = 8'h00;
        tx_eof  = 1'b0;
        forever begin
            @(posedge clk_50mhz); #1;
            if (tx_ack === 1'b1) begin
                acked++;
                ack_total++;
            end else if (busy !== 1'b1) begin
                acked = 0;
            end
            tx_data = (acked < 1600) ? payload[acked] : 8'h00;
            tx_eof  = (acked == frame_len);
        end
    end

    // Receiver: rebuilds bytes from dibits, records frame lengths, gaps and idle runs.
    initial begin
        int run;
        int gap;
        int idle_run;
        logic [7:0] acc;
        run = 0; gap = -1; idle_run = 0; acc = 8'h00;
        forever begin
            @(posedge clk_50mhz); #1;
            if (rmii_txen === 1'b1) begin
                if (run == 0 && gap >= 0) gap_q.push_back(gap);
                acc[2*(run%4) +: 2] = rmii_txd;
                run++;
                if (run % 4 == 0) rx_q.push_back(acc);
            end else begin
                if (run > 0) begin
                    len_q.push_back(run);
                    run = 0;
                    gap = 0;
                end
                if (gap >= 0) gap++;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_run = run;
            end
            if (frame_err === 1'b1) err_cnt++;
            if (busy === 1'b1) begin
                if (idle_run > 0) idle_q.push_back(idle_run);
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
    end

    task automatic fill_payload();
        for (int i = 0; i < 1600; i++) payload[i] = 8'($urandom);
    endtask

    // Scoreboard push: the wire image expected for an n-byte request, returns its byte count.
    function automatic int push_expected(input int n);
        int m;
        int body;
        logic [31:0] c;
        logic [7:0]  b;
        m = (n > 1514) ? 1514 : n;
        body = (m < 60) ? 60 : m;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < body; i++) begin
            b = (i < m) ? payload[i] : 8'h00;
            c = ref_crc(c, b);
            exp_q.push_back(b);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(~c[8*i +: 8]);
        return 8 + body + 4;
    endfunction

    task automatic wait_busy(input logic level, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk_50mhz); #2;
            ok = (busy === level);
        end
    endtask

    task automatic run_frame(input int n, output int n_exp, output logic ok);
        fill_payload();
        frame_len = n;
        n_exp = push_expected(n);
        tx_sof = 1'b1;
        wait_busy(1'b1, 100, ok);
        tx_sof = 1'b0;
        if (ok) wait_busy(1'b0, 8000, ok);
    endtask

    // Scoreboard pop: compares one received frame with the expected image, gathers length and residue.
    task automatic collect_frame(input int n_exp, output int len, output int mism, output logic [31:0] res);
        logic [7:0] e;
        logic [7:0] r;
        len  = (len_q.size() > 0) ? len_q.pop_front() : -1;
        mism = 0;
        res  = 32'hFFFFFFFF;
        for (int i = 0; i < n_exp; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            if (rx_q.size() == 0) begin
                mism++;
            end else begin
                r = rx_q.pop_front();
                if (r !== e) mism++;
                if (i >= 8) res = ref_crc(res, r);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_50mhz);
        #2;
        checks++;
        if ({rmii_txen, rmii_txd, tx_ack, busy, frame_done, frame_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_held outputs=%b want=0000000", {rmii_txen, rmii_txd, tx_ack, busy, frame_done, frame_err});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk_50mhz);
        #2;
        checks++;
        if ({rmii_txen, rmii_txd, tx_ack, busy, frame_done, frame_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle outputs=%b want=0000000", {rmii_txen, rmii_txd, tx_ack, busy, frame_done, frame_err});
        end
    endtask

    task automatic test_crc_unit();
        string s;
        s = "123456789";
        unit_crc = 32'hFFFFFFFF;
        for (int i = 0; i < s.len(); i++) begin
            unit_data = s[i];
            #1;
            unit_crc = unit_next;
        end
        checks++;
        if (~unit_crc !== 32'hCBF43926) begin
            failures++;
            $display("FAIL crc_check got=%h want=cbf43926", ~unit_crc);
        end
    endtask

    task automatic test_short_frame();
        int a0, d0, e0, n_exp, len, mism;
        logic ok;
        logic [31:0] res;
        a0 = ack_total; d0 = done_cnt; e0 = err_cnt;
        run_frame(42, n_exp, ok);
        collect_frame(n_exp, len, mism, res);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL short_timeout got=%b want=1", ok); end
        checks++; if (ack_total - a0 !== 42) begin failures++; $display("FAIL short_acks got=%0d want=42", ack_total - a0); end
        checks++; if (len !== 288) begin failures++; $display("FAIL short_txen_len got=%0d want=288", len); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL short_done got=%0d want=1", done_cnt - d0); end
        checks++; if (done_run !== len) begin failures++; $display("FAIL short_done_pos got=%0d want=%0d", done_run, len); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL short_err got=%0d want=0", err_cnt - e0); end
        checks++; if (mism !== 0) begin failures++; $display("FAIL short_bytes mismatched=%0d want=0", mism); end
        checks++; if (res !== 32'hDEBB20E3) begin failures++; $display("FAIL short_residue got=%h want=debb20e3", res); end
    endtask

    task automatic test_back_to_back();
        int a0, d0, n1, n2, len, mism, gap, idle;
        logic ok, ok_all;
        logic [31:0] res;
        a0 = ack_total; d0 = done_cnt;
        fill_payload();
        frame_len = 100;
        n1 = push_expected(100);
        tx_sof = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk_50mhz); #2;
            ok = (rmii_txen === 1'b1);
        end
        ok_all = ok;
        gap_q.delete();
        idle_q.delete();
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk_50mhz); #2;
            ok = (done_cnt != d0);
        end
        ok_all &= ok;
        fill_payload();
        n2 = push_expected(100);
        wait_busy(1'b0, 200, ok); ok_all &= ok;
        wait_busy(1'b1, 10, ok);  ok_all &= ok;
        tx_sof = 1'b0;
        wait_busy(1'b0, 8000, ok); ok_all &= ok;
        gap  = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
        idle = (idle_q.size() > 0) ? idle_q.pop_front() : -1;
        checks++; if (ok_all !== 1'b1) begin failures++; $display("FAIL b2b_timeout got=%b want=1", ok_all); end
        checks++; if (gap !== 48) begin failures++; $display("FAIL b2b_gap got=%0d want=48", gap); end
        checks++; if (idle !== 1) begin failures++; $display("FAIL b2b_idle got=%0d want=1", idle); end
        checks++; if (ack_total - a0 !== 200) begin failures++; $display("FAIL b2b_acks got=%0d want=200", ack_total - a0); end
        checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL b2b_done got=%0d want=2", done_cnt - d0); end
        collect_frame(n1, len, mism, res);
        checks++; if (len !== 448) begin failures++; $display("FAIL b2b_len1 got=%0d want=448", len); end
        checks++; if (mism !== 0 || res !== 32'hDEBB20E3) begin failures++; $display("FAIL b2b_frame1 mismatched=%0d residue=%h want=0/debb20e3", mism, res); end
        collect_frame(n2, len, mism, res);
        checks++; if (len !== 448) begin failures++; $display("FAIL b2b_len2 got=%0d want=448", len); end
        checks++; if (mism !== 0 || res !== 32'hDEBB20E3) begin failures++; $display("FAIL b2b_frame2 mismatched=%0d residue=%h want=0/debb20e3", mism, res); end
    endtask

    task automatic test_truncation();
        int a0, d0, e0, n_exp, len, mism;
        logic ok;
        logic [31:0] res;
        a0 = ack_total; d0 = done_cnt; e0 = err_cnt;
        run_frame(1600, n_exp, ok);
        collect_frame(n_exp, len, mism, res);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL trunc_timeout got=%b want=1", ok); end
        checks++; if (ack_total - a0 !== 1514) begin failures++; $display("FAIL trunc_acks got=%0d want=1514", ack_total - a0); end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL trunc_err got=%0d want=1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL trunc_done got=%0d want=1", done_cnt - d0); end
        checks++; if (len !== 6104) begin failures++; $display("FAIL trunc_len got=%0d want=6104", len); end
        checks++; if (mism !== 0) begin failures++; $display("FAIL trunc_bytes mismatched=%0d want=0", mism); end
        checks++; if (res !== 32'hDEBB20E3) begin failures++; $display("FAIL trunc_residue got=%h want=debb20e3", res); end
    endtask

    task automatic test_max_frame();
        int a0, e0, n_exp, len, mism;
        logic ok;
        logic [31:0] res;
        a0 = ack_total; e0 = err_cnt;
        run_frame(1514, n_exp, ok);
        collect_frame(n_exp, len, mism, res);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL max_timeout got=%b want=1", ok); end
        checks++; if (ack_total - a0 !== 1514) begin failures++; $display("FAIL max_acks got=%0d want=1514", ack_total - a0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL max_err got=%0d want=0", err_cnt - e0); end
        checks++; if (len !== 6104) begin failures++; $display("FAIL max_len got=%0d want=6104", len); end
        checks++; if (mism !== 0 || res !== 32'hDEBB20E3) begin failures++; $display("FAIL max_frame mismatched=%0d residue=%h want=0/debb20e3", mism, res); end
    endtask

    task automatic test_reset_mid_frame();
        int a0, d0, n_exp, len, mism;
        logic ok;
        logic [31:0] res;
        a0 = ack_total;
        fill_payload();
        frame_len = 100;
        tx_sof = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk_50mhz); #2;
            ok = (tx_ack === 1'b1 && ack_total - a0 == 20);
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL midrst_reach got=%b want=1", ok); end
        rst = 1'b1;
        #1;
        checks++; if (rmii_txen !== 1'b0) begin failures++; $display("FAIL midrst_txen got=%b want=0", rmii_txen); end
        checks++; if (tx_ack !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b want=0", tx_ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
        tx_sof = 1'b0;
        repeat (3) @(posedge clk_50mhz);
        #2;
        rst = 1'b0;
        @(posedge clk_50mhz); #2;
        rx_q.delete();
        len_q.delete();
        exp_q.delete();
        a0 = ack_total; d0 = done_cnt;
        run_frame(64, n_exp, ok);
        collect_frame(n_exp, len, mism, res);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL postrst_timeout got=%b want=1", ok); end
        checks++; if (ack_total - a0 !== 64) begin failures++; $display("FAIL postrst_acks got=%0d want=64", ack_total - a0); end
        checks++; if (len !== 304) begin failures++; $display("FAIL postrst_len got=%0d want=304", len); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL postrst_done got=%0d want=1", done_cnt - d0); end
        checks++; if (mism !== 0 || res !== 32'hDEBB20E3) begin failures++; $display("FAIL postrst_frame mismatched=%0d residue=%h want=0/debb20e3", mism, res); end
    endtask

    initial begin
        test_reset();
        test_crc_unit();
        test_short_frame();
        test_back_to_back();
        test_truncation();
        test_max_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
